// File: rtl/cw_dec_pkg.sv
// rtl/cw_dec_pkg.sv - shared defaults, FSM state encoding and width helper for cw_decode
`timescale 1ns/1ps
package cw_dec_pkg;

  localparam int CW_W_DEF = 13;
  localparam int U_DEF    = 4;
  localparam int QMAX_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT_CW = 3'd1,
    ST_UNARY   = 3'd2,
    ST_STOP0   = 3'd3,
    ST_REM     = 3'd4,
    ST_FLUSH   = 3'd5,
    ST_DONE    = 3'd6
  } cw_state_t;

  // Remainder bit counter width; never narrower than one bit.
  function automatic int rem_cnt_w(input int u);
    return (u > 1) ? $clog2(u) : 1;
  endfunction

endpackage

// File: rtl/cw_bit_packer.sv
// rtl/cw_bit_packer.sv - MSB-first bit-to-byte packer with zero-padded flush and byte backpressure
`timescale 1ns/1ps
module cw_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  input  logic       flush,
  output logic [7:0] msg_byte,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       empty
);

  logic [7:0] sr;
  logic [2:0] cnt;
  logic       slot_free;
  logic       take_bit;
  logic       load_flush;
  logic [7:0] padded;

  // A byte leaving this cycle frees the output slot, so the next bit needs no bubble.
  assign slot_free  = ~byte_valid | byte_ready;
  assign bit_ready  = slot_free;
  assign take_bit   = bit_valid & slot_free;
  assign load_flush = flush & ~take_bit & (cnt != 3'd0) & slot_free;
  assign padded     = sr << (4'd8 - {1'b0, cnt});
  assign empty      = (cnt == 3'd0) & ~byte_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr         <= 8'd0;
      cnt        <= 3'd0;
      msg_byte   <= 8'd0;
      byte_valid <= 1'b0;
    end else if (clear) begin
      cnt        <= 3'd0;
      byte_valid <= 1'b0;
    end else begin
      if (byte_valid & byte_ready)
        byte_valid <= 1'b0;
      if (take_bit) begin
        sr <= {sr[6:0], bit_in};
        if (cnt == 3'd7) begin
          msg_byte   <= {sr[6:0], bit_in};
          byte_valid <= 1'b1;
          cnt        <= 3'd0;
        end else begin
          cnt <= cnt + 3'd1;
        end
      end else if (load_flush) begin
        msg_byte   <= padded;
        byte_valid <= 1'b1;
        cnt        <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/cw_decode.sv
// rtl/cw_decode.sv - Golomb-Rice gap decoder from codeword positions to message bytes
// Optional CW_DEC_ORDER_CHECK_EN: out-of-order codeword raises err and ends the session.
`timescale 1ns/1ps
module cw_decode
  import cw_dec_pkg::*;
#(
  parameter int CW_W = CW_W_DEF,
  parameter int T    = 10,
  parameter int U    = U_DEF,
  parameter int QMAX = QMAX_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW_W-1:0] cw_in,
  input  logic            cw_valid,
  output logic            cw_ready,
  output logic [7:0]      msg_byte,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic            done,
  output logic            err
);

  localparam int QW    = CW_W - U;
  localparam int RW    = rem_cnt_w(U);
  localparam int CNT_W = $clog2(T + 1);

  cw_state_t        state, state_nx;
  logic [CW_W-1:0]  base;
  logic [QW-1:0]    q_cnt;
  logic [U-1:0]     r_sh;
  logic [RW-1:0]    r_idx;
  logic [CNT_W-1:0] cw_cnt;
  logic             err_r;

  logic [CW_W-1:0]  d;
  logic [QW-1:0]    q;
  logic             bad_cw;
  logic             restart;
  logic             bit_in, bit_valid, bit_ready, flush, pk_empty;

  assign d       = cw_in - base;
  assign q       = d[CW_W-1:U];
  assign restart = start & ((state == ST_IDLE) | (state == ST_DONE));
`ifdef CW_DEC_ORDER_CHECK_EN
  assign bad_cw  = (q > QW'(QMAX)) | (cw_in < base);
`else
  assign bad_cw  = (q > QW'(QMAX));
`endif
  assign done    = (state == ST_DONE);
  assign err     = err_r;

  always_comb begin
    state_nx  = state;
    cw_ready  = 1'b0;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    flush     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_WAIT_CW;
      ST_WAIT_CW: begin
        cw_ready = 1'b1;
        if (cw_valid) begin
          if (bad_cw)        state_nx = ST_DONE;
          else if (q != '0)  state_nx = ST_UNARY;
          else               state_nx = ST_STOP0;
        end
      end
      ST_UNARY: begin
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        if (bit_ready && q_cnt == QW'(1)) state_nx = ST_STOP0;
      end
      ST_STOP0: begin
        bit_valid = 1'b1;
        if (bit_ready) state_nx = ST_REM;
      end
      ST_REM: begin
        bit_valid = 1'b1;
        bit_in    = r_sh[U-1];
        if (bit_ready && r_idx == RW'(U - 1))
          state_nx = (cw_cnt == CNT_W'(T)) ? ST_FLUSH : ST_WAIT_CW;
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (pk_empty) state_nx = ST_DONE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      base   <= '0;
      q_cnt  <= '0;
      r_sh   <= '0;
      r_idx  <= '0;
      cw_cnt <= '0;
      err_r  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE, ST_DONE: if (start) begin
          base   <= '0;
          cw_cnt <= '0;
          err_r  <= 1'b0;
        end
        ST_WAIT_CW: if (cw_valid) begin
          if (bad_cw) begin
            err_r <= 1'b1;
          end else begin
            base   <= cw_in + CW_W'(1);
            q_cnt  <= q;
            r_sh   <= d[U-1:0];
            r_idx  <= '0;
            cw_cnt <= cw_cnt + CNT_W'(1);
          end
        end
        ST_UNARY: if (bit_ready) q_cnt <= q_cnt - QW'(1);
        ST_REM: if (bit_ready) begin
          r_sh  <= r_sh << 1;
          r_idx <= r_idx + RW'(1);
        end
        default: ;
      endcase
    end
  end

  // Cleared on restart so an error-terminated session leaves no stale bits behind.
  cw_bit_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (restart),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .flush      (flush),
    .msg_byte   (msg_byte),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .empty      (pk_empty)
  );

endmodule

// File: tb/tb_cw_decode.sv
// tb/tb_cw_decode.sv - self-checking bench for cw_decode against a gap-expansion reference model
`timescale 1ns/1ps
module tb_cw_decode;

  localparam int CW_W = 13;
  localparam int T    = 2;
  localparam int U    = 4;
  localparam int QMAX = 15;
  localparam int MODV = 1 << CW_W;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CW_W-1:0] cw_in;
  logic            cw_valid;
  logic            cw_ready;
  logic [7:0]      msg_byte;
  logic            byte_valid;
  logic            byte_ready;
  logic            done;
  logic            err;

  int tests = 0;
  int fails = 0;

  int         ready_mode = 0;
  int         bp_cnt = 0;
  int         bp_bad = 0;
  int         cw_list[$];
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  bit         exp_err;

  always #5 clk = ~clk;

  cw_decode #(.CW_W(CW_W), .T(T), .U(U), .QMAX(QMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cw_in      (cw_in),
    .cw_valid   (cw_valid),
    .cw_ready   (cw_ready),
    .msg_byte   (msg_byte),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Consumer: ready is chosen at the falling edge, so a byte seen valid here with ready set transfers next rise.
  initial begin
    byte_ready = 1'b1;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0: byte_ready = 1'b1;
        1: byte_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (byte_valid && bp_cnt < 20) begin
            byte_ready = 1'b0;
            if (msg_byte !== 8'hCA) bp_bad++;
            bp_cnt++;
          end else begin
            byte_ready = 1'b1;
          end
        end
      endcase
      if (byte_valid && byte_ready && !rst) got_q.push_back(msg_byte);
    end
  end

  // Reference: expand each gap into unary quotient, stop bit and U remainder bits, then group into bytes.
  task automatic build_model();
    int base = 0;
    int d, q, r, v;
    bit bits[$];
    exp_q.delete();
    exp_err = 1'b0;
    foreach (cw_list[i]) begin
      d = (cw_list[i] - base + MODV) % MODV;
      q = d / (1 << U);
      r = d % (1 << U);
`ifdef CW_DEC_ORDER_CHECK_EN
      if (cw_list[i] < base) exp_err = 1'b1;
`endif
      if (q > QMAX) exp_err = 1'b1;
      if (exp_err) break;
      repeat (q) bits.push_back(1'b1);
      bits.push_back(1'b0);
      for (int k = U - 1; k >= 0; k--) bits.push_back(((r >> k) % 2) == 1);
      base = (cw_list[i] + 1) % MODV;
    end
    while (bits.size() >= 8 || (bits.size() > 0 && !exp_err)) begin
      v = 0;
      for (int k = 0; k < 8; k++) begin
        v = v * 2;
        if (bits.size() > 0) v = v + int'(bits.pop_front());
      end
      exp_q.push_back(v[7:0]);
    end
  endtask

  task automatic run_session(input string tag);
    int guard;
    build_model();
    got_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    foreach (cw_list[i]) begin
      cw_in    = cw_list[i][CW_W-1:0];
      cw_valid = 1'b1;
      guard    = 0;
      while (!cw_ready && !done && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (done) begin
        cw_valid = 1'b0;
        break;
      end
      if (guard >= 500) begin
        check($sformatf("%s_cw_timeout", tag), 32'd0, 32'd1);
        cw_valid = 1'b0;
        return;
      end
      @(negedge clk);
      cw_valid = 1'b0;
      check($sformatf("%s_ready_low%0d", tag, i), {31'd0, cw_ready}, 32'd0);
    end
    guard = 0;
    while (!done && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check($sformatf("%s_done", tag), {31'd0, done}, 32'd1);
    repeat (3) @(negedge clk);
    check($sformatf("%s_err", tag), {31'd0, err}, {31'd0, exp_err});
    check($sformatf("%s_nbytes", tag), got_q.size(), exp_q.size());
    foreach (exp_q[i])
      if (i < got_q.size())
        check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
  endtask

  task automatic check_case1_bytes(input string tag);
    check($sformatf("%s_ca", tag), (got_q.size() > 0) ? {24'd0, got_q[0]} : 32'hFFFF, 32'h00CA);
    check($sformatf("%s_20", tag), (got_q.size() > 1) ? {24'd0, got_q[1]} : 32'hFFFF, 32'h0020);
  endtask

  initial begin
    int c1;
    rst      = 1'b1;
    start    = 1'b0;
    cw_in    = '0;
    cw_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cw_ready",   {31'd0, cw_ready},   32'd0);
    check("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_err",        {31'd0, err},        32'd0);
    check("rst_msg_byte",   {24'd0, msg_byte},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    cw_list = '{37, 40};
    run_session("case1");
    check_case1_bytes("case1");

    ready_mode = 2; bp_cnt = 0; bp_bad = 0;
    run_session("bp");
    check_case1_bytes("bp");
    check("bp_stall_cycles", bp_cnt, 20);
    check("bp_hold_stable", bp_bad, 0);
    ready_mode = 0;

    cw_list = '{0, 16};
    run_session("zero_gap");

    cw_list = '{256, 300};
    run_session("qmax");
    check("qmax_ready_stays_low", {31'd0, cw_ready}, 32'd0);
    check("qmax_err", {31'd0, err}, 32'd1);

    cw_list = '{100, 50};
    run_session("order");
    check("order_err", {31'd0, err}, 32'd1);

    // Reset while the first codeword's remainder is being emitted.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cw_in = 13'd37; cw_valid = 1'b1;
    @(negedge clk); cw_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_cw_ready",   {31'd0, cw_ready},   32'd0);
    check("midrst_byte_valid", {31'd0, byte_valid}, 32'd0);
    check("midrst_done",       {31'd0, done},       32'd0);
    check("midrst_err",        {31'd0, err},        32'd0);
    check("midrst_msg_byte",   {24'd0, msg_byte},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    cw_list = '{37, 40};
    run_session("after_rst");
    check_case1_bytes("after_rst");

    for (int s = 0; s < 25; s++) begin
      ready_mode = $urandom_range(0, 1);
      c1 = ($urandom_range(0, 5) == 0) ? $urandom_range(256, 1200) : $urandom_range(0, 255);
      cw_list = '{c1, c1 + 1 + $urandom_range(0, 255)};
      run_session($sformatf("rnd%0d", s));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
